lt24_qsys_sysid_ext: RTL and testbench

// Parametrised system-identification and uptime slave on the Qsys Avalon-MM fabric.
// - Generalises the fixed two-word ID slave into an 8-word register file.
// - Words: ID, build timestamp, 64-bit uptime counter with atomic snapshot, seconds counter,

---
 rtl/lt24_qsys_sysid_ext.sv | 135 +++++++++++++
 tb/tb_lt24_qsys_sysid_ext.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lt24_qsys_sysid_ext.sv
// System-ID / uptime slave: 8-word Avalon-MM register file with ID, build stamp,
// an atomically readable uptime counter, a seconds counter, scratch, control and
// capability words. Reads have a fixed READ_LATENCY with a readdatavalid pulse.
// Legal ranges: ADDR_W >= 3, READ_LATENCY 1..3, UPTIME_W 33..64, CLK_FREQ_HZ >= 2.
module lt24_qsys_sysid_ext #(
    parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'd1403259050,
    parameter int          ADDR_W        = 3,
    parameter int          READ_LATENCY  = 1,
    parameter int          UPTIME_W      = 64,
    parameter int          CLK_FREQ_HZ   = 50000000,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);
    localparam int SH_W = UPTIME_W - 32;
    localparam int PS_W = $clog2(CLK_FREQ_HZ);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_FREQ_HZ - 1);

    logic [UPTIME_W-1:0] uptime_q, uptime_d;
    logic [PS_W-1:0]     presc_q, presc_d;
    logic [31:0]         seconds_q, seconds_d;
    logic [SH_W-1:0]     shadow_q, shadow_d;
    logic [31:0]         scratch_q, scratch_d;
    logic                freeze_q, freeze_d;

    logic [READ_LATENCY-1:0]       vld_q;
    logic [READ_LATENCY-1:0][31:0] dat_q;

    logic        rd_en;
    logic        ctrl_wr;
    logic        clear;
    logic [31:0] rd_word;

    // A write wins over a simultaneous read; the read is simply dropped.
    assign rd_en   = read & ~write;
    assign ctrl_wr = write & (address == ADDR_W'(6)) & byteenable[0];
    assign clear   = ctrl_wr & writedata[1];

    // Read mux over the pre-edge register state; unmapped words read as zero.
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_W'(0): rd_word = SYSTEM_ID;
            ADDR_W'(1): rd_word = TIMESTAMP;
            ADDR_W'(2): rd_word = uptime_q[31:0];
            ADDR_W'(3): rd_word = 32'(shadow_q);
            ADDR_W'(4): rd_word = seconds_q;
            ADDR_W'(5): rd_word = scratch_q;
            ADDR_W'(6): rd_word = {31'b0, freeze_q};
            ADDR_W'(7): rd_word = {16'h5349, 8'(UPTIME_W), 8'(READ_LATENCY)};
            default:    rd_word = '0;
        endcase
    end

    // Next state: register writes, shadow capture and the uptime/seconds counters.
    always_comb begin
        scratch_d = scratch_q;
        freeze_d  = freeze_q;
        shadow_d  = shadow_q;
        uptime_d  = uptime_q;
        presc_d   = presc_q;
        seconds_d = seconds_q;

        if (write && address == ADDR_W'(5)) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
        end
        if (ctrl_wr) freeze_d = writedata[0];

        // Latch the high half alongside a LO read so LO-then-HI is coherent.
        if (rd_en && address == ADDR_W'(2)) shadow_d = uptime_q[UPTIME_W-1:32];

        // CLEAR overrides both counting and FREEZE.
        if (clear) begin
            uptime_d  = '0;
            presc_d   = '0;
            seconds_d = '0;
        end else if (!freeze_q) begin
            uptime_d = uptime_q + UPTIME_W'(1);
            if (presc_q == PS_LAST) begin
                presc_d   = '0;
                seconds_d = seconds_q + 32'd1;
            end else begin
                presc_d = presc_q + PS_W'(1);
            end
        end
    end

    // Architectural state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uptime_q  <= '0;
            presc_q   <= '0;
            seconds_q <= '0;
            shadow_q  <= '0;
            scratch_q <= SCRATCH_RESET;
            freeze_q  <= 1'b0;
        end else begin
            uptime_q  <= uptime_d;
            presc_q   <= presc_d;
            seconds_q <= seconds_d;
            shadow_q  <= shadow_d;
            scratch_q <= scratch_d;
            freeze_q  <= freeze_d;
        end
    end

    // Read response pipeline; reset flushes every in-flight response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= rd_en;
            dat_q[0] <= rd_en ? rd_word : 32'h0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign readdata      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_lt24_qsys_sysid_ext.sv
// Bench for lt24_qsys_sysid_ext: three instances (read latency 1, 2, 3) share one
// stimulus stream and are compared against a behavioural register-file model.
module tb_lt24_qsys_sysid_ext;
    localparam logic [31:0] SYS_ID = 32'hC0DE_5EED;
    localparam logic [31:0] TSTAMP = 32'd1403259050;
    localparam logic [31:0] SCR_RST = 32'h5A5A_0F0F;
    localparam int FREQ = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rd1, rd2, rd3;
    logic        v1, v2, v3;

    always #5 clock = ~clock;

    lt24_qsys_sysid_ext #(.SYSTEM_ID(SYS_ID), .ADDR_W(4), .READ_LATENCY(1), .UPTIME_W(64),
        .CLK_FREQ_HZ(FREQ), .SCRATCH_RESET(SCR_RST)) u_l1 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd1), .readdatavalid(v1));
    lt24_qsys_sysid_ext #(.SYSTEM_ID(SYS_ID), .ADDR_W(4), .READ_LATENCY(2), .UPTIME_W(64),
        .CLK_FREQ_HZ(FREQ), .SCRATCH_RESET(SCR_RST)) u_l2 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd2), .readdatavalid(v2));
    lt24_qsys_sysid_ext #(.SYSTEM_ID(SYS_ID), .ADDR_W(4), .READ_LATENCY(3), .UPTIME_W(64),
        .CLK_FREQ_HZ(FREQ), .SCRATCH_RESET(SCR_RST)) u_l3 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd3), .readdatavalid(v3));

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int p3cnt = 0;

    // Reference model state
    longint unsigned m_up;
    int unsigned     m_pre, m_sec;
    logic [31:0]     m_scr, m_shadow;
    bit              m_frz;
    // Per-edge read history: was a response issued, its data, was it the INFO word
    bit          hv[$];
    logic [31:0] hd[$];
    bit          hinfo[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0: return SYS_ID;
            1: return TSTAMP;
            2: return m_up[31:0];
            3: return m_shadow;
            4: return m_sec;
            5: return m_scr;
            6: return {31'b0, m_frz};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_up = 0; m_pre = 0; m_sec = 0; m_shadow = 0; m_scr = SCR_RST; m_frz = 0;
        foreach (hv[i]) hv[i] = 0;
    endtask

    task automatic model_edge(input bit rd, input bit wr, input int a,
                              input logic [31:0] wd, input logic [3:0] be);
        bit rv, clr, nf;
        rv = rd && !wr;
        hv.push_back(rv);
        hd.push_back(rv ? m_read(a) : 32'h0);
        hinfo.push_back(rv && a == 7);
        if (rv && a == 2) m_shadow = m_up[63:32];
        clr = 0;
        nf  = m_frz;
        if (wr && a == 5)
            for (int b = 0; b < 4; b++) if (be[b]) m_scr[8*b +: 8] = wd[8*b +: 8];
        if (wr && a == 6 && be[0]) begin nf = wd[0]; clr = wd[1]; end
        if (clr) begin
            m_up = 0; m_pre = 0; m_sec = 0;
        end else if (!m_frz) begin
            m_up++;
            m_pre++;
            if (m_pre == FREQ) begin m_pre = 0; m_sec++; end
        end
        m_frz = nf;
        cyc++;
    endtask

    task automatic chk_pipe(input int lat, input logic v, input logic [31:0] d);
        int  idx;
        bit  ev;
        idx = cyc - lat;
        ev  = (idx >= 0) ? hv[idx] : 1'b0;
        chk($sformatf("rdv_L%0d", lat), {63'b0, v}, {63'b0, ev});
        if (ev && v)
            chk($sformatf("rdata_L%0d", lat), {32'b0, d},
                {32'b0, hinfo[idx] ? {16'h5349, 8'd64, 8'(lat)} : hd[idx]});
    endtask

    task automatic check_pipes();
        chk_pipe(1, v1, rd1);
        chk_pipe(2, v2, rd2);
        chk_pipe(3, v3, rd3);
        if (v3) p3cnt++;
    endtask

    // One bus cycle: drive at negedge, update model at posedge, check at next negedge.
    task automatic step(input bit rd, input bit wr, input int a,
                        input logic [31:0] wd, input logic [3:0] be);
        read = rd; write = wr; address = 4'(a); writedata = wd; byteenable = be;
        @(posedge clock);
        model_edge(rd, wr, a, wd, be);
        @(negedge clock);
        check_pipes();
        read = 0; write = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 4'h0);
    endtask

    // Assert reset mid-cycle (async), hold for n edges, release at a negedge.
    task automatic do_reset(input int n);
        read = 0; write = 0;
        reset = 1;
        model_reset();
        #1;
        chk("rst_rdv", {61'b0, v1, v2, v3}, 64'h0);
        chk("rst_rdata", {rd1, rd3}, 64'h0);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            hv.push_back(0); hd.push_back(0); hinfo.push_back(0);
            cyc++;
            @(negedge clock);
            check_pipes();
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; read = 0; write = 0; address = 0; writedata = 0; byteenable = 0;
        model_reset();
        @(negedge clock);
        do_reset(2);

        // ID / timestamp / INFO, one cycle after the read
        step(1, 0, 0, 0, 0); chk("id", {63'b0, v1}, 64'h1); chk("id_val", {32'b0, rd1}, {32'b0, SYS_ID});
        step(1, 0, 1, 0, 0); chk("tstamp", {32'b0, rd1}, 64'd1403259050);
        step(1, 0, 7, 0, 0); chk("info", {32'b0, rd1}, 64'h5349_4001);
        // 10 edges after reset with a 4-cycle second: seconds == 2
        idle(7);
        step(1, 0, 4, 0, 0); chk("seconds2", {32'b0, rd1}, 64'd2);

        // Back-to-back burst with latency 3: eight in-order pulses
        idle(3);
        p3cnt = 0;
        for (int a = 0; a < 8; a++) step(1, 0, a, 0, 0);
        idle(3);
        chk("burst_L3_count", 64'(p3cnt), 64'd8);

        // Scratch byte lanes
        step(0, 1, 5, 32'h1122_3344, 4'hF);
        step(0, 1, 5, 32'hAABB_CCDD, 4'b0101);
        step(1, 0, 5, 0, 0); chk("scratch_be", {32'b0, rd1}, 64'h11BB_33DD);

        // CLEAR with a colliding read: no response, counters zeroed
        idle(5);
        step(1, 1, 6, 32'h2, 4'h1); chk("clr_no_rdv", {63'b0, v1}, 64'h0);
        step(1, 0, 2, 0, 0); chk("clr_uptime", {32'b0, rd1}, 64'h0);
        step(1, 0, 4, 0, 0); chk("clr_seconds", {32'b0, rd1}, 64'h0);

        // Uptime wrap: freeze, preload, then read LO then HI
        step(0, 1, 6, 32'h1, 4'h1);
        force u_l1.uptime_q = 64'h1_FFFF_FFFF;
        force u_l2.uptime_q = 64'h1_FFFF_FFFF;
        force u_l3.uptime_q = 64'h1_FFFF_FFFF;
        m_up = 64'h1_FFFF_FFFF;
        idle(1);
        release u_l1.uptime_q;
        release u_l2.uptime_q;
        release u_l3.uptime_q;
        step(1, 0, 2, 0, 0); chk("wrap_lo", {32'b0, rd1}, 64'hFFFF_FFFF);
        step(1, 0, 3, 0, 0); chk("wrap_hi", {32'b0, rd1}, 64'h1);
        step(0, 1, 6, 32'h0, 4'h1);
        step(1, 0, 2, 0, 0); chk("wrap_edge_lo", {32'b0, rd1}, 64'hFFFF_FFFF);
        step(1, 0, 3, 0, 0); chk("wrap_edge_hi", {32'b0, rd1}, 64'h1);
        step(1, 0, 3, 0, 0); chk("hi_stable", {32'b0, rd1}, 64'h1);

        // Reset while reads are in flight: no late pulses, scratch restored
        step(1, 0, 0, 0, 0);
        do_reset(2);
        idle(3);
        step(1, 0, 5, 0, 0); chk("scratch_rst", {32'b0, rd1}, {32'b0, SCR_RST});

        // Randomised traffic, including unmapped words and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1);
            end else begin
                int unsigned a;
                a = $urandom_range(0, 15);
                step($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, int'(a),
                     $urandom, 4'($urandom_range(0, 15)));
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
